// File: rtl/reg_write_demux_pkg.sv
// Shared definitions for the register write demux: default widths, the
// hardwired zero-register index and the COUNT width helper.
package reg_write_demux_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int ZERO_REG = 0;

  // COUNT must represent 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// AW -> 2**AW one-hot decoder with enable; inverse of the read mux tree.
module decoder_onehot #(
  parameter int AW = 5
) (
  input  logic              en,
  input  logic [AW-1:0]     addr,
  output logic [2**AW-1:0]  onehot
);

  // single line raised only when enabled
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_write_demux.sv
// Register write demux: buffers write requests in a small FIFO and drains
// one per cycle into a registered one-hot write enable + shared data bus.
// Also offers a pending-write lookup for the read path.
// Optional feature macro: REG_WRITE_DEMUX_FWD_EN (youngest-match data forward).
module reg_write_demux
  import reg_write_demux_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int CW   = cnt_w(DEPTH),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [DW-1:0]     WR_DATA,
  input  logic              HOLD,
  output logic [2**AW-1:0]  REG_WE,
  output logic [AW-1:0]     REG_WADDR,
  output logic [DW-1:0]     REG_WDATA,
  output logic [CW-1:0]     COUNT,
  input  logic [AW-1:0]     RD_ADDR,
  output logic              PEND_HIT,
  output logic [DW-1:0]     FWD_DATA
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2**AW-1:0]   reg_we_q, reg_we_d, dec_we;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               push, pop;
  entry_t             head;

  // ready depends on occupancy only, so a pop at the same edge cannot admit a push
  assign WR_READY = (count_q != CW'(DEPTH));
  assign push     = WR_VALID & WR_READY;
  assign pop      = ~HOLD & (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  // zero register never gets an enable line, though it still drains
  decoder_onehot #(.AW(AW)) u_dec (
    .en     (pop && (head.addr != AW'(ZERO_REG))),
    .addr   (head.addr),
    .onehot (dec_we)
  );

  // FIFO bookkeeping and output-stage next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    reg_we_d = dec_we;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (push) begin
      mem_d[wr_ptr_q].addr = WR_ADDR;
      mem_d[wr_ptr_q].data = WR_DATA;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      waddr_d  = head.addr;
      wdata_d  = head.data;
    end
  end

  // control and output stage; async reset discards buffered writes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      reg_we_q <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      reg_we_q <= reg_we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // storage needs no reset; validity comes from the pointers and count
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign REG_WE    = reg_we_q;
  assign REG_WADDR = waddr_q;
  assign REG_WDATA = wdata_q;
  assign COUNT     = count_q;

  // pending lookup: scan oldest -> youngest so the youngest match wins,
  // with the output stage (older than any buffered entry) checked first
  logic [DW-1:0] fwd;
  always_comb begin
    PEND_HIT = 1'b0;
    fwd      = '0;
    if (RD_ADDR != AW'(ZERO_REG)) begin
      if ((|reg_we_q) && (waddr_q == RD_ADDR)) begin
        PEND_HIT = 1'b1;
`ifdef REG_WRITE_DEMUX_FWD_EN
        fwd      = wdata_q;
`endif
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < count_q) && (mem_q[rd_ptr_q + PW'(k)].addr == RD_ADDR)) begin
          PEND_HIT = 1'b1;
`ifdef REG_WRITE_DEMUX_FWD_EN
          fwd      = mem_q[rd_ptr_q + PW'(k)].data;
`endif
        end
      end
    end
  end

`ifdef REG_WRITE_DEMUX_FWD_EN
  assign FWD_DATA = fwd;
`else
  assign FWD_DATA = '0;
`endif

endmodule

// File: tb/tb_reg_write_demux.sv
// Directed bench for reg_write_demux (DEPTH=4, AW=5, DW=32).
module tb_reg_write_demux;

  logic        CLK, RST, WR_VALID, WR_READY, HOLD, PEND_HIT;
  logic [4:0]  WR_ADDR, REG_WADDR, RD_ADDR;
  logic [31:0] WR_DATA, REG_WE, REG_WDATA, FWD_DATA;
  logic [2:0]  COUNT;

  int total = 0;
  int bad   = 0;

  reg_write_demux #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .HOLD(HOLD), .REG_WE(REG_WE),
    .REG_WADDR(REG_WADDR), .REG_WDATA(REG_WDATA), .COUNT(COUNT),
    .RD_ADDR(RD_ADDR), .PEND_HIT(PEND_HIT), .FWD_DATA(FWD_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  // one clock edge, then sample 1ns later
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] oh(input logic [4:0] a);
    logic [31:0] v;
    v = 32'h1 << a;
    return v;
  endfunction

  function automatic logic [31:0] fwd_exp(input logic [31:0] d);
`ifdef REG_WRITE_DEMUX_FWD_EN
    return d;
`else
    return 32'h0;
`endif
  endfunction

  initial begin
    RST = 1'b0; WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0; HOLD = 1'b0; RD_ADDR = '0;

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_we",    REG_WE, 32'h0);
    chk("rst_count", {29'b0, COUNT}, 32'd0);
    chk("rst_ready", {31'b0, WR_READY}, 32'd1);
    chk("rst_wdata", REG_WDATA, 32'h0);
    chk("rst_waddr", {27'b0, REG_WADDR}, 32'd0);
    chk("rst_pend",  {31'b0, PEND_HIT}, 32'd0);
    chk("rst_fwd",   FWD_DATA, 32'h0);
    RST = 1'b1;

    // single write: push at edge 1, enable visible after edge 2
    WR_VALID = 1'b1; WR_ADDR = 5'd5; WR_DATA = 32'hDEADBEEF; RD_ADDR = 5'd5;
    step();
    WR_VALID = 1'b0;
    chk("sw_count1", {29'b0, COUNT}, 32'd1);
    chk("sw_we_early", REG_WE, 32'h0);
    chk("sw_pend_buf", {31'b0, PEND_HIT}, 32'd1);
    chk("sw_fwd_buf", FWD_DATA, fwd_exp(32'hDEADBEEF));
    step();
    chk("sw_we",    REG_WE, 32'h00000020);
    chk("sw_wdata", REG_WDATA, 32'hDEADBEEF);
    chk("sw_waddr", {27'b0, REG_WADDR}, 32'd5);
    chk("sw_count0", {29'b0, COUNT}, 32'd0);
    chk("sw_pend_stage", {31'b0, PEND_HIT}, 32'd1);
    step();
    chk("sw_we_off", REG_WE, 32'h0);
    chk("sw_wdata_hold", REG_WDATA, 32'hDEADBEEF);
    chk("sw_pend_off", {31'b0, PEND_HIT}, 32'd0);

    // fill to full with HOLD; 5th request must be refused
    HOLD = 1'b1; WR_VALID = 1'b1; RD_ADDR = 5'd3;
    for (int i = 1; i <= 5; i++) begin
      WR_ADDR = 5'(i); WR_DATA = 32'h100 + 32'(i);
      step();
      chk("fill_count", {29'b0, COUNT}, (i < 4) ? 32'(i) : 32'd4);
      chk("fill_ready", {31'b0, WR_READY}, (i < 4) ? 32'd1 : 32'd0);
      chk("fill_we", REG_WE, 32'h0);
    end
    chk("fill_pend", {31'b0, PEND_HIT}, 32'd1);
    // release: addr 5 still offered, admitted only after the first pop
    HOLD = 1'b0;
    step();
    chk("drain_we1", REG_WE, oh(5'd1));
    chk("drain_cnt1", {29'b0, COUNT}, 32'd3);
    chk("drain_rdy1", {31'b0, WR_READY}, 32'd1);
    step();
    WR_VALID = 1'b0;
    chk("drain_we2", REG_WE, oh(5'd2));
    chk("drain_cnt2", {29'b0, COUNT}, 32'd3);
    for (int j = 3; j <= 5; j++) begin
      step();
      chk("drain_we", REG_WE, oh(5'(j)));
      chk("drain_data", REG_WDATA, 32'h100 + 32'(j));
    end
    chk("drain_cnt_end", {29'b0, COUNT}, 32'd0);
    step();
    chk("drain_idle", REG_WE, 32'h0);

    // zero register: slot used, no enable, no pending hit
    WR_VALID = 1'b1; WR_ADDR = 5'd0; WR_DATA = 32'h12345678; RD_ADDR = 5'd0;
    step();
    WR_VALID = 1'b0;
    chk("z_count", {29'b0, COUNT}, 32'd1);
    chk("z_pend_buf", {31'b0, PEND_HIT}, 32'd0);
    step();
    chk("z_we", REG_WE, 32'h0);
    chk("z_wdata", REG_WDATA, 32'h12345678);
    chk("z_waddr", {27'b0, REG_WADDR}, 32'd0);
    chk("z_pend_stage", {31'b0, PEND_HIT}, 32'd0);
    chk("z_fwd", FWD_DATA, 32'h0);
    step();

    // same address twice: youngest forwards, drain in order
    HOLD = 1'b1; WR_VALID = 1'b1; WR_ADDR = 5'd7; WR_DATA = 32'h11; RD_ADDR = 5'd7;
    step();
    WR_DATA = 32'h22;
    step();
    WR_VALID = 1'b0;
    chk("ord_count", {29'b0, COUNT}, 32'd2);
    chk("ord_pend", {31'b0, PEND_HIT}, 32'd1);
    chk("ord_fwd", FWD_DATA, fwd_exp(32'h22));
    HOLD = 1'b0;
    step();
    chk("ord_we1", REG_WE, oh(5'd7));
    chk("ord_d1", REG_WDATA, 32'h11);
    chk("ord_fwd_mix", FWD_DATA, fwd_exp(32'h22));
    step();
    chk("ord_we2", REG_WE, oh(5'd7));
    chk("ord_d2", REG_WDATA, 32'h22);
    chk("ord_fwd_stage", FWD_DATA, fwd_exp(32'h22));
    step();
    chk("ord_pend_off", {31'b0, PEND_HIT}, 32'd0);
    chk("ord_fwd_off", FWD_DATA, 32'h0);

    // reset in the middle of a drain
    HOLD = 1'b1; WR_VALID = 1'b1; RD_ADDR = 5'd2;
    for (int i = 1; i <= 4; i++) begin
      WR_ADDR = 5'(i); WR_DATA = 32'hA0 + 32'(i);
      step();
    end
    WR_VALID = 1'b0; HOLD = 1'b0;
    step();
    chk("mr_count3", {29'b0, COUNT}, 32'd3);
    chk("mr_we_act", REG_WE, oh(5'd1));
    #2 RST = 1'b0;
    #1;
    chk("mr_we_rst", REG_WE, 32'h0);
    chk("mr_cnt_rst", {29'b0, COUNT}, 32'd0);
    chk("mr_wdata_rst", REG_WDATA, 32'h0);
    chk("mr_pend_rst", {31'b0, PEND_HIT}, 32'd0);
    #1 RST = 1'b1;
    step();
    chk("mr_no_stale1", REG_WE, 32'h0);
    chk("mr_cnt_post", {29'b0, COUNT}, 32'd0);
    step();
    chk("mr_no_stale2", REG_WE, 32'h0);

    // streaming: 16 back-to-back writes, one pulse per cycle in order
    HOLD = 1'b0; RD_ADDR = 5'd0;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        WR_VALID = 1'b1; WR_ADDR = 5'((i % 31) + 1); WR_DATA = 32'h1000 * 32'(i) + 32'(i);
      end else begin
        WR_VALID = 1'b0;
      end
      step();
      chk("st_ready", {31'b0, WR_READY}, 32'd1);
      if (i >= 1) begin
        chk("st_we", REG_WE, oh(5'(((i - 1) % 31) + 1)));
        chk("st_data", REG_WDATA, 32'h1000 * 32'(i - 1) + 32'(i - 1));
      end
    end
    step();
    chk("st_idle", REG_WE, 32'h0);
    chk("st_cnt", {29'b0, COUNT}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
